// File: rtl/trace_scan_harness_pkg.sv
// Shared types for the trace/scan self-check harness: FSM states and
// the default field widths that make up one packed trace entry.
package trace_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SCAN_ADDR,
        S_SCAN_CMP,
        S_DONE
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CYC_W  = 16;

    // A trace entry packs {cycle, register, data} from MSB to LSB.
    function automatic int entry_w(input int cyc_w, input int reg_aw, input int data_w);
        return cyc_w + reg_aw + data_w;
    endfunction

endpackage

// File: rtl/trace_scan_harness_fifo.sv
// First-word-fall-through FIFO holding trace entries; the head is always
// visible on o_data while the FIFO is non-empty.
module trace_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_data   = r_mem[r_rdPtr];
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_doPop  = i_pop && !o_empty && !i_clear;
    assign w_doPush = i_push && (!o_full || w_doPop) && !i_clear;

    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/trace_scan_harness.sv
// Self-check harness: logs regfile writebacks for a cycle budget, then
// scans every register against an expected-value ROM and reports pass/fail.
module trace_scan_harness
    import trace_scan_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int NUM_REGS   = 32,
    parameter int CYC_W      = DEF_CYC_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic              rwe,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] rdata,
    output logic              test_mode,
    output logic [REG_AW-1:0] rs1_test,
    input  logic [DATA_W-1:0] regA,
    output logic [REG_AW-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [CYC_W-1:0]  trace_cycle,
    output logic [REG_AW-1:0] trace_rd,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_overflow,
    output logic              mm_valid,
    output logic [REG_AW-1:0] mm_reg,
    output logic [DATA_W-1:0] mm_exp,
    output logic [DATA_W-1:0] mm_act,
    output logic [REG_AW:0]   err_count,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int ENTRY_W = entry_w(CYC_W, REG_AW, DATA_W);
    localparam int ERR_W   = REG_AW + 1;

    state_t              r_state;
    state_t              w_nextState;
    logic [CYC_W-1:0]    r_cyc;
    logic [CYC_W-1:0]    r_budget;
    logic [REG_AW-1:0]   r_idx;
    logic                r_overflow;
    logic [ERR_W-1:0]    r_errCount;
    logic                r_mmValid;
    logic [REG_AW-1:0]   r_mmReg;
    logic [DATA_W-1:0]   r_mmExp;
    logic [DATA_W-1:0]   r_mmAct;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_startOk;
    logic                w_runLast;
    logic                w_log;
    logic                w_pop;
    logic                w_push;
    logic                w_mismatch;
    logic                w_lastIdx;

    assign w_startOk  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_runLast  = (r_state == S_RUN) && (r_cyc == r_budget - CYC_W'(1));
    assign w_log      = (r_state == S_RUN) && rwe && (rd != '0);
    assign w_pop      = !w_empty && trace_ready;
    assign w_push     = w_log && (!w_full || w_pop);
    assign w_mismatch = (r_state == S_SCAN_CMP) && (regA != exp_data);
    assign w_lastIdx  = (r_idx == REG_AW'(NUM_REGS - 1));

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_startOk),
        .i_push  (w_push),
        .i_data  ({r_cyc, rd, rdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_nextState = (num_cycles == '0) ? S_SCAN_ADDR : S_RUN;
            S_RUN:          if (w_runLast) w_nextState = S_SCAN_ADDR;
            S_SCAN_ADDR:    w_nextState = S_SCAN_CMP;
            S_SCAN_CMP:     w_nextState = w_lastIdx ? S_DONE : S_SCAN_ADDR;
            default:        w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cyc      <= '0;
            r_budget   <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
            r_errCount <= '0;
            r_mmValid  <= 1'b0;
            r_mmReg    <= '0;
            r_mmExp    <= '0;
            r_mmAct    <= '0;
        end else begin
            r_mmValid <= 1'b0;
            if (w_startOk) begin
                r_cyc      <= '0;
                r_budget   <= num_cycles;
                r_idx      <= '0;
                r_errCount <= '0;
                r_overflow <= 1'b0;
            end
            if (r_state == S_RUN) begin
                r_cyc <= r_cyc + CYC_W'(1);
                if (w_log && w_full && !w_pop) r_overflow <= 1'b1;
            end
            if (r_state == S_SCAN_CMP) begin
                if (!w_lastIdx) r_idx <= r_idx + REG_AW'(1);
                if (w_mismatch) begin
                    r_mmValid  <= 1'b1;
                    r_mmReg    <= r_idx;
                    r_mmExp    <= exp_data;
                    r_mmAct    <= regA;
                    r_errCount <= (r_errCount == '1) ? r_errCount : r_errCount + ERR_W'(1);
                end
            end
        end
    end

    // Trace fields read as zero while the FIFO is empty so reset leaves every output low.
    assign trace_valid    = !w_empty;
    assign trace_data     = w_empty ? '0 : w_head[DATA_W-1:0];
    assign trace_rd       = w_empty ? '0 : w_head[DATA_W +: REG_AW];
    assign trace_cycle    = w_empty ? '0 : w_head[DATA_W+REG_AW +: CYC_W];
    assign trace_overflow = r_overflow;

    assign test_mode = (r_state == S_SCAN_ADDR) || (r_state == S_SCAN_CMP);
    assign rs1_test  = test_mode ? r_idx : '0;
    assign exp_addr  = test_mode ? r_idx : '0;
    assign mm_valid  = r_mmValid;
    assign mm_reg    = r_mmReg;
    assign mm_exp    = r_mmExp;
    assign mm_act    = r_mmAct;
    assign err_count = r_errCount;
    assign busy      = (r_state == S_RUN) || test_mode;
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_errCount == '0) && !r_overflow;

endmodule

// File: tb/tb_trace_scan_harness.sv
// Directed bench for trace_scan_harness with a behavioural regfile and
// registered expected-value ROM.
module tb_trace_scan_harness;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CYC_W  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CYC_W-1:0]  num_cycles = '0;
    logic              rwe = 1'b0;
    logic [REG_AW-1:0] rd = '0;
    logic [DATA_W-1:0] rdata = '0;
    logic              test_mode;
    logic [REG_AW-1:0] rs1_test;
    logic [DATA_W-1:0] regA;
    logic [REG_AW-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data = '0;
    logic              trace_valid;
    logic              trace_ready = 1'b0;
    logic [CYC_W-1:0]  trace_cycle;
    logic [REG_AW-1:0] trace_rd;
    logic [DATA_W-1:0] trace_data;
    logic              trace_overflow;
    logic              mm_valid;
    logic [REG_AW-1:0] mm_reg;
    logic [DATA_W-1:0] mm_exp;
    logic [DATA_W-1:0] mm_act;
    logic [REG_AW:0]   err_count;
    logic              busy;
    logic              done;
    logic              pass;

    logic [DATA_W-1:0] regFile [32];
    logic [DATA_W-1:0] romArr  [32];
    int checks = 0;
    int failures = 0;

    trace_scan_harness dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .rdata(rdata), .test_mode(test_mode), .rs1_test(rs1_test),
        .regA(regA), .exp_addr(exp_addr), .exp_data(exp_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_cycle(trace_cycle),
        .trace_rd(trace_rd), .trace_data(trace_data), .trace_overflow(trace_overflow),
        .mm_valid(mm_valid), .mm_reg(mm_reg), .mm_exp(mm_exp), .mm_act(mm_act),
        .err_count(err_count), .busy(busy), .done(done), .pass(pass)
    );

    always #5 clock = ~clock;
    assign regA = regFile[rs1_test];
    always @(posedge clock) exp_data <= romArr[exp_addr];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic startRun(input logic [CYC_W-1:0] n);
        num_cycles = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic romMatchAll;
        for (int i = 0; i < 32; i++) romArr[i] = regFile[i];
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("[TB] FAIL wait_done: timed out after %0d cycles", n); end
    endtask

    task automatic test_reset;
        #2;
        checks++; if (busy !== 1'b0)        begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)        begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (pass !== 1'b0)        begin failures++; $display("[TB] FAIL reset_pass: got %b want 0", pass); end
        checks++; if (test_mode !== 1'b0)   begin failures++; $display("[TB] FAIL reset_test_mode: got %b want 0", test_mode); end
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_trace_valid: got %b want 0", trace_valid); end
        checks++; if (err_count !== '0)     begin failures++; $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0)        begin failures++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_trace;
        int nEntries;
        logic [CYC_W-1:0]  gotCyc;
        logic [REG_AW-1:0] gotRd;
        logic [DATA_W-1:0] gotData;
        nEntries = 0; gotCyc = '0; gotRd = '0; gotData = '0;
        romMatchAll();
        trace_ready = 1'b1;
        startRun(16'd5);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL run_busy: got %b want 1", busy); end
        for (int c = 0; c < 5; c++) begin
            rwe   = (c == 1 || c == 2);
            rd    = (c == 1) ? 5'd3 : 5'd0;
            rdata = (c == 1) ? 32'd7 : 32'd9;
            tick();
            if (trace_valid) begin
                nEntries++;
                gotCyc = trace_cycle; gotRd = trace_rd; gotData = trace_data;
            end
        end
        rwe = 1'b0;
        checks++; if (nEntries != 1)     begin failures++; $display("[TB] FAIL basic_entries: got %0d want 1", nEntries); end
        checks++; if (gotCyc !== 16'd1)  begin failures++; $display("[TB] FAIL basic_cycle: got %0d want 1", gotCyc); end
        checks++; if (gotRd !== 5'd3)    begin failures++; $display("[TB] FAIL basic_rd: got %0d want 3", gotRd); end
        checks++; if (gotData !== 32'd7) begin failures++; $display("[TB] FAIL basic_data: got %0d want 7", gotData); end
        waitDone(200);
        checks++; if (err_count !== '0) begin failures++; $display("[TB] FAIL basic_err: got %0d want 0", err_count); end
        checks++; if (pass !== 1'b1)    begin failures++; $display("[TB] FAIL basic_pass: got %b want 1", pass); end
    endtask

    task automatic test_overflow;
        trace_ready = 1'b0;
        startRun(16'd20);
        for (int c = 0; c < 20; c++) begin
            rwe   = 1'b1;
            rd    = 5'(c % 31 + 1);
            rdata = 32'(1000 + c);
            tick();
        end
        rwe = 1'b0;
        checks++; if (trace_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b want 1", trace_overflow); end
        checks++; if (trace_cycle !== 16'd0)   begin failures++; $display("[TB] FAIL ovf_head: got %0d want 0", trace_cycle); end
        tick();
        checks++; if (trace_rd !== 5'd1)       begin failures++; $display("[TB] FAIL ovf_hold_rd: got %0d want 1", trace_rd); end
        waitDone(200);
        checks++; if (pass !== 1'b0)           begin failures++; $display("[TB] FAIL ovf_pass: got %b want 0", pass); end
        checks++; if (err_count !== '0)        begin failures++; $display("[TB] FAIL ovf_err: got %0d want 0", err_count); end
        trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (trace_cycle !== 16'(k))      begin failures++; $display("[TB] FAIL ovf_drain_cycle: got %0d want %0d", trace_cycle, k); end
            checks++; if (trace_data !== 32'(1000 + k)) begin failures++; $display("[TB] FAIL ovf_drain_data: got %0d want %0d", trace_data, 1000 + k); end
            tick();
        end
        trace_ready = 1'b0;
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained: got %b want 0", trace_valid); end
    endtask

    task automatic test_back_to_back;
        trace_ready = 1'b0;
        startRun(16'd12);
        checks++; if (trace_overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ovf_clear: got %b want 0", trace_overflow); end
        for (int c = 0; c < 12; c++) begin
            rwe   = 1'b1;
            rd    = 5'(c + 1);
            rdata = 32'(200 + c);
            if (c >= 8) begin
                trace_ready = 1'b1;
                checks++; if (trace_cycle !== 16'(c - 8)) begin failures++; $display("[TB] FAIL b2b_head: got %0d want %0d", trace_cycle, c - 8); end
            end
            tick();
        end
        rwe = 1'b0;
        for (int k = 4; k < 12; k++) begin
            checks++; if (trace_cycle !== 16'(k))     begin failures++; $display("[TB] FAIL b2b_drain_cycle: got %0d want %0d", trace_cycle, k); end
            checks++; if (trace_rd !== 5'(k + 1))     begin failures++; $display("[TB] FAIL b2b_drain_rd: got %0d want %0d", trace_rd, k + 1); end
            checks++; if (trace_data !== 32'(200 + k)) begin failures++; $display("[TB] FAIL b2b_drain_data: got %0d want %0d", trace_data, 200 + k); end
            tick();
        end
        checks++; if (trace_valid !== 1'b0)    begin failures++; $display("[TB] FAIL b2b_empty: got %b want 0", trace_valid); end
        checks++; if (trace_overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ovf: got %b want 0", trace_overflow); end
        waitDone(200);
        checks++; if (pass !== 1'b1) begin failures++; $display("[TB] FAIL b2b_pass: got %b want 1", pass); end
    endtask

    task automatic test_scan_mismatch;
        int mmCount;
        int doneAt;
        logic [REG_AW-1:0] gotReg;
        logic [DATA_W-1:0] gotExp;
        logic [DATA_W-1:0] gotAct;
        mmCount = 0; doneAt = -1; gotReg = '0; gotExp = '0; gotAct = '0;
        regFile[5] = 32'd11;
        romMatchAll();
        romArr[5] = 32'd10;
        trace_ready = 1'b1;
        rwe = 1'b0;
        startRun(16'd2);
        tick();
        tick();
        checks++; if (test_mode !== 1'b1) begin failures++; $display("[TB] FAIL scan_entry_mode: got %b want 1", test_mode); end
        checks++; if (rs1_test !== 5'd0)  begin failures++; $display("[TB] FAIL scan_entry_rs1: got %0d want 0", rs1_test); end
        for (int t = 1; t <= 70 && doneAt < 0; t++) begin
            tick();
            if (mm_valid) begin
                mmCount++;
                gotReg = mm_reg; gotExp = mm_exp; gotAct = mm_act;
            end
            if (t == 2) begin
                checks++; if (exp_addr !== 5'd1) begin failures++; $display("[TB] FAIL scan_exp_addr: got %0d want 1", exp_addr); end
            end
            if (done && doneAt < 0) doneAt = t;
        end
        checks++; if (doneAt != 64)       begin failures++; $display("[TB] FAIL scan_length: got %0d want 64", doneAt); end
        checks++; if (mmCount != 1)       begin failures++; $display("[TB] FAIL mm_pulses: got %0d want 1", mmCount); end
        checks++; if (gotReg !== 5'd5)    begin failures++; $display("[TB] FAIL mm_reg: got %0d want 5", gotReg); end
        checks++; if (gotExp !== 32'd10)  begin failures++; $display("[TB] FAIL mm_exp: got %0d want 10", gotExp); end
        checks++; if (gotAct !== 32'd11)  begin failures++; $display("[TB] FAIL mm_act: got %0d want 11", gotAct); end
        checks++; if (err_count !== 6'd1) begin failures++; $display("[TB] FAIL mm_err_count: got %0d want 1", err_count); end
        checks++; if (pass !== 1'b0)      begin failures++; $display("[TB] FAIL mm_pass: got %b want 0", pass); end
        checks++; if (test_mode !== 1'b0) begin failures++; $display("[TB] FAIL done_test_mode: got %b want 0", test_mode); end
        regFile[5] = 32'(5 * 16 + 3);
    endtask

    task automatic test_direct_scan;
        int doneAt;
        doneAt = -1;
        romMatchAll();
        startRun(16'd0);
        checks++; if (test_mode !== 1'b1) begin failures++; $display("[TB] FAIL direct_mode: got %b want 1", test_mode); end
        checks++; if (err_count !== '0)   begin failures++; $display("[TB] FAIL direct_err_clear: got %0d want 0", err_count); end
        for (int t = 1; t <= 70 && doneAt < 0; t++) begin
            if (t == 10) begin
                start = 1'b1;
                num_cycles = 16'd3;
            end
            tick();
            start = 1'b0;
            if (done && doneAt < 0) doneAt = t;
        end
        checks++; if (doneAt != 64)         begin failures++; $display("[TB] FAIL direct_length: got %0d want 64", doneAt); end
        checks++; if (pass !== 1'b1)        begin failures++; $display("[TB] FAIL direct_pass: got %b want 1", pass); end
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("[TB] FAIL direct_no_trace: got %b want 0", trace_valid); end
    endtask

    task automatic test_reset_mid;
        romMatchAll();
        romArr[0] = 32'hdead;
        trace_ready = 1'b0;
        startRun(16'd3);
        for (int c = 0; c < 3; c++) begin
            rwe = 1'b1; rd = 5'(c + 1); rdata = 32'(50 + c);
            tick();
        end
        rwe = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (err_count !== 6'd1)   begin failures++; $display("[TB] FAIL mid_err_before: got %0d want 1", err_count); end
        checks++; if (trace_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_trace_before: got %b want 1", trace_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (test_mode !== 1'b0)   begin failures++; $display("[TB] FAIL mid_test_mode: got %b want 0", test_mode); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("[TB] FAIL mid_busy: got %b want 0", busy); end
        checks++; if (rs1_test !== '0)      begin failures++; $display("[TB] FAIL mid_rs1: got %0d want 0", rs1_test); end
        checks++; if (err_count !== '0)     begin failures++; $display("[TB] FAIL mid_err: got %0d want 0", err_count); end
        checks++; if (mm_exp !== '0)        begin failures++; $display("[TB] FAIL mid_mm_exp: got %0h want 0", mm_exp); end
        checks++; if (trace_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_trace: got %b want 0", trace_valid); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mid_idle: got busy=%b done=%b want 0/0", busy, done); end
        romArr[0] = regFile[0];
    endtask

    initial begin
        regFile[0] = '0;
        for (int i = 1; i < 32; i++) regFile[i] = 32'(i * 16 + 3);
        romMatchAll();
        test_reset();
        test_basic_trace();
        test_overflow();
        test_back_to_back();
        test_scan_mismatch();
        test_direct_scan();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
